// File: rtl/obi_mem_pkg.sv
// Shared types for the OBI memory arbiter: port identifiers and the
// response-tracking stage record.
package obi_mem_pkg;

  // Port identifier; also the encoding of the arbiter's last_grant pointer.
  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_id_e;

  // One stage of the response pipeline: is an access in flight, which
  // port issued it, and whether it was a write (writes return zero data).
  typedef struct packed {
    logic     valid;
    port_id_e owner;
    logic     we;
  } rsp_stage_t;

  // Largest memory latency the response pipeline is meant to track.
  localparam int MAX_MEM_LATENCY = 4;

endpackage

// File: rtl/obi_rr_arbiter.sv
// Two-way arbiter between the instruction port (req_i[0]) and the data port
// (req_i[1]). Round-robin on conflicts, or fixed data priority.
module obi_rr_arbiter
  import obi_mem_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output port_id_e   winner_o
);

  port_id_e last_grant_q;

  // Pick the winner; on a conflict the port that did not win last time goes,
  // unless the data port has fixed priority.
  always_comb begin
    winner_o = INSTR;
    gnt_o    = 2'b00;
    if (req_i == 2'b11) begin
      if (PRIORITY_MODE == 1) begin
        winner_o = DATA;
      end else begin
        winner_o = (last_grant_q == DATA) ? INSTR : DATA;
      end
    end else if (req_i[1]) begin
      winner_o = DATA;
    end
    if (req_i != 2'b00) begin
      gnt_o = (winner_o == DATA) ? 2'b10 : 2'b01;
    end
  end

  // The pointer follows every grant, so a port that was just served alone
  // loses the next conflict.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= DATA;
    end else if (req_i != 2'b00) begin
      last_grant_q <= winner_o;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the instruction fetch
// port and the data port. One access per cycle, responses routed back to
// the issuing port exactly MEM_LATENCY cycles after its grant.
//
// Handshake: a port raises req with stable fields and holds them until it
// sees gnt in the same cycle; gnt means the access went to memory this
// cycle. rvalid is a one-cycle pulse that cannot be stalled, so requesters
// must always accept it. Responses come back in grant order.
module obi_mem_arbiter
  import obi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [31:0]             conflict_cnt_o
);

  logic [1:0]  arb_req;
  logic [1:0]  arb_gnt;
  port_id_e    winner;
  logic [31:0] conflict_cnt_q;
  rsp_stage_t  pipe_q [MEM_LATENCY];
  rsp_stage_t  rsp_last;
  logic        rsp_valid;

  // Requests are masked during reset so no grant or memory access leaks out.
  assign arb_req = {data_req_i & rst_ni, instr_req_i & rst_ni};

  obi_rr_arbiter #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (arb_req),
    .gnt_o   (arb_gnt),
    .winner_o(winner)
  );

  assign instr_gnt_o = arb_gnt[0];
  assign data_gnt_o  = arb_gnt[1];

  // Drive the memory with the winner's fields; fetches are full-word reads.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (arb_gnt[1]) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (arb_gnt[0]) begin
      mem_req_o   = 1'b1;
      mem_be_o    = '1;
      mem_addr_o  = instr_addr_i;
    end
  end

  // Count cycles where both ports asked, sticking at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (instr_req_i && data_req_i && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = rst_ni ? conflict_cnt_q : 32'd0;

  // Track each access through the memory latency; reset drops everything
  // in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{valid: mem_req_o, owner: winner, we: mem_we_o};
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rsp_last  = pipe_q[MEM_LATENCY-1];
  assign rsp_valid = rsp_last.valid & rst_ni;

  // Route the returning data to its owner; writes and the idle port see zero.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    if (rsp_valid) begin
      if (rsp_last.owner == DATA) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = rsp_last.we ? '0 : mem_rdata_i;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = rsp_last.we ? '0 : mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter. Three instances share the stimulus:
//   a_* : MEM_LATENCY=1, round-robin
//   b_* : MEM_LATENCY=3, round-robin
//   c_* : MEM_LATENCY=1, fixed data priority
// Each instance has its own memory model returning (address + 1).
module tb_obi_mem_arbiter;

  localparam int W = 34;  // {valid, port, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;

  // ---------------- per-instance outputs ----------------
  logic a_instr_gnt, a_instr_rvalid, a_data_gnt, a_data_rvalid, a_mem_req, a_mem_we;
  logic [31:0] a_instr_rdata, a_data_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_conflict;
  logic [3:0]  a_mem_be;
  logic b_instr_gnt, b_instr_rvalid, b_data_gnt, b_data_rvalid, b_mem_req, b_mem_we;
  logic [31:0] b_instr_rdata, b_data_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata, b_conflict;
  logic [3:0]  b_mem_be;
  logic c_instr_gnt, c_instr_rvalid, c_data_gnt, c_data_rvalid, c_mem_req, c_mem_we;
  logic [31:0] c_instr_rdata, c_data_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata, c_conflict;
  logic [3:0]  c_mem_be;

  obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .PRIORITY_MODE(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(a_instr_gnt),
    .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
    .data_wdata_i(data_wdata), .data_gnt_o(a_data_gnt), .data_rvalid_o(a_data_rvalid),
    .data_rdata_o(a_data_rdata), .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
    .conflict_cnt_o(a_conflict)
  );

  obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .PRIORITY_MODE(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(b_instr_gnt),
    .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
    .data_wdata_i(data_wdata), .data_gnt_o(b_data_gnt), .data_rvalid_o(b_data_rvalid),
    .data_rdata_o(b_data_rdata), .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
    .conflict_cnt_o(b_conflict)
  );

  obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .PRIORITY_MODE(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(c_instr_gnt),
    .instr_rvalid_o(c_instr_rvalid), .instr_rdata_o(c_instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
    .data_wdata_i(data_wdata), .data_gnt_o(c_data_gnt), .data_rvalid_o(c_data_rvalid),
    .data_rdata_o(c_data_rdata), .mem_req_o(c_mem_req), .mem_we_o(c_mem_we), .mem_be_o(c_mem_be),
    .mem_addr_o(c_mem_addr), .mem_wdata_o(c_mem_wdata), .mem_rdata_i(c_mem_rdata),
    .conflict_cnt_o(c_conflict)
  );

  // ---------------- memory models: data = address + 1 after the latency ----------------
  logic [31:0] a_m1;
  logic [31:0] c_m1;
  logic [31:0] b_m [3];
  always @(posedge clk) begin
    a_m1   <= a_mem_addr;
    c_m1   <= c_mem_addr;
    b_m[0] <= b_mem_addr;
    b_m[1] <= b_m[0];
    b_m[2] <= b_m[1];
  end
  assign a_mem_rdata = a_m1 + 32'd1;
  assign c_mem_rdata = c_m1 + 32'd1;
  assign b_mem_rdata = b_m[2] + 32'd1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    instr_req  = 1'b0;
    instr_addr = 32'd0;
    data_req   = 1'b0;
    data_addr  = 32'd0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_wdata = 32'd0;
  endtask

  task automatic drive_instr(input logic req, input logic [31:0] addr);
    instr_req  = req;
    instr_addr = addr;
  endtask

  task automatic drive_data(input logic req, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata);
    data_req   = req;
    data_addr  = addr;
    data_we    = we;
    data_be    = be;
    data_wdata = wdata;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_idle();
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  // ---------------- directed sequence ----------------
  logic [31:0] t1_addr  [4] = '{32'h80, 32'h84, 32'h88, 32'h8C};
  logic [31:0] t1_rdata [4] = '{32'h81, 32'h85, 32'h89, 32'h8D};
  logic        t2_igrant[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [W-1:0] e;
    logic         odd;

    // Reset state, with both requests asserted to show nothing leaks.
    rst_n = 1'b0;
    set_idle();
    drive_instr(1'b1, 32'h44);
    drive_data(1'b1, 32'h88, 1'b1, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst instr_gnt", {31'd0, a_instr_gnt}, 32'd0);
    check("rst data_gnt", {31'd0, a_data_gnt}, 32'd0);
    check("rst mem_req", {31'd0, a_mem_req}, 32'd0);
    check("rst mem_we", {31'd0, a_mem_we}, 32'd0);
    check("rst mem_be", {28'd0, a_mem_be}, 32'd0);
    check("rst mem_addr", a_mem_addr, 32'd0);
    check("rst mem_wdata", a_mem_wdata, 32'd0);
    check("rst instr_rvalid", {31'd0, a_instr_rvalid}, 32'd0);
    check("rst data_rvalid", {31'd0, a_data_rvalid}, 32'd0);
    check("rst data_rdata", a_data_rdata, 32'd0);
    step();
    check("rst conflict", a_conflict, 32'd0);
    rst_n = 1'b1;
    set_idle();

    // Instruction-only stream, latency 1.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_instr(1'b1, t1_addr[k]);
      else       set_idle();
      @(negedge clk);
      if (k < 4) begin
        check("t1 instr_gnt", {31'd0, a_instr_gnt}, 32'd1);
        check("t1 mem_addr", a_mem_addr, t1_addr[k]);
        check("t1 mem_be", {28'd0, a_mem_be}, 32'hF);
      end
      if (k >= 1) begin
        check("t1 instr_rvalid", {31'd0, a_instr_rvalid}, 32'd1);
        check("t1 instr_rdata", a_instr_rdata, t1_rdata[k-1]);
      end
      check("t1 data_rvalid", {31'd0, a_data_rvalid}, 32'd0);
      step();
    end
    @(negedge clk);
    check("t1 rvalid drop", {31'd0, a_instr_rvalid}, 32'd0);
    step();

    // Round-robin conflict right after reset: instr, data, instr, data.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        drive_instr(1'b1, 32'h100);
        drive_data(1'b1, 32'h200, 1'b0, 4'hF, 32'd0);
      end else begin
        set_idle();
      end
      @(negedge clk);
      if (k < 4) begin
        check("t2 instr_gnt", {31'd0, a_instr_gnt}, {31'd0, t2_igrant[k]});
        check("t2 data_gnt", {31'd0, a_data_gnt}, {31'd0, !t2_igrant[k]});
      end
      if (k >= 1) begin
        check("t2 instr_rvalid", {31'd0, a_instr_rvalid}, {31'd0, t2_igrant[k-1]});
        check("t2 data_rvalid", {31'd0, a_data_rvalid}, {31'd0, !t2_igrant[k-1]});
        check("t2 instr_rdata", a_instr_rdata, t2_igrant[k-1] ? 32'h101 : 32'd0);
        check("t2 data_rdata", a_data_rdata, t2_igrant[k-1] ? 32'd0 : 32'h201);
      end
      if (k == 4) check("t2 conflict_cnt", a_conflict, 32'd4);
      step();
    end
    idle_cycles(3);

    // Fixed data priority: instr starves for 3 cycles, then gets through.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k < 4) drive_instr(1'b1, 32'h300);
      if (k < 3) drive_data(1'b1, 32'h340, 1'b0, 4'hF, 32'd0);
      @(negedge clk);
      if (k < 3) begin
        check("t3 data_gnt", {31'd0, c_data_gnt}, 32'd1);
        check("t3 instr_gnt", {31'd0, c_instr_gnt}, 32'd0);
      end else if (k == 3) begin
        check("t3 instr_gnt late", {31'd0, c_instr_gnt}, 32'd1);
        check("t3 data_gnt late", {31'd0, c_data_gnt}, 32'd0);
      end else begin
        check("t3 conflict_cnt", c_conflict, 32'd3);
        check("t3 instr_rdata", c_instr_rdata, 32'h301);
      end
      step();
    end
    idle_cycles(3);

    // Store: fields pass through, response carries zero data.
    drive_data(1'b1, 32'h1000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t4 data_gnt", {31'd0, a_data_gnt}, 32'd1);
    check("t4 mem_req", {31'd0, a_mem_req}, 32'd1);
    check("t4 mem_we", {31'd0, a_mem_we}, 32'd1);
    check("t4 mem_be", {28'd0, a_mem_be}, 32'h3);
    check("t4 mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    check("t4 mem_addr", a_mem_addr, 32'h1000);
    step();
    set_idle();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t4 a data_rvalid", {31'd0, a_data_rvalid}, (k == 1) ? 32'd1 : 32'd0);
      check("t4 a data_rdata", a_data_rdata, 32'd0);
      check("t4 b data_rvalid", {31'd0, b_data_rvalid}, (k == 3) ? 32'd1 : 32'd0);
      check("t4 b data_rdata", b_data_rdata, 32'd0);
      check("t4 b instr_rvalid", {31'd0, b_instr_rvalid}, 32'd0);
      step();
    end
    idle_cycles(2);

    // Latency 3, interleaved instr/data reads back-to-back.
    apply_reset();
    exp_q.delete();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      odd = c[0];
      if (c < 6) begin
        if (!odd) drive_instr(1'b1, 32'h400 + 32'(c * 4));
        else      drive_data(1'b1, 32'h800 + 32'(c * 4), 1'b0, 4'hF, 32'd0);
      end
      @(negedge clk);
      if (c < 6) begin
        check("t5 instr_gnt", {31'd0, b_instr_gnt}, {31'd0, !odd});
        check("t5 data_gnt", {31'd0, b_data_gnt}, {31'd0, odd});
      end
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        check("t5 instr_rvalid", {31'd0, b_instr_rvalid}, {31'd0, e[33] & !e[32]});
        check("t5 data_rvalid", {31'd0, b_data_rvalid}, {31'd0, e[33] & e[32]});
        check("t5 instr_rdata", b_instr_rdata, (e[33] && !e[32]) ? e[31:0] : 32'd0);
        check("t5 data_rdata", b_data_rdata, (e[33] && e[32]) ? e[31:0] : 32'd0);
      end
      if (c < 6) exp_q.push_back({1'b1, odd, (odd ? 32'h800 : 32'h400) + 32'(c * 4) + 32'd1});
      else       exp_q.push_back({1'b0, 1'b0, 32'd0});
      step();
    end

    // Reset with two reads in flight: they vanish, pointer and counter reset.
    set_idle();
    drive_instr(1'b1, 32'h40);
    drive_data(1'b1, 32'h50, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    check("t6 pre instr_gnt", {31'd0, b_instr_gnt}, 32'd1);
    step();
    set_idle();
    drive_instr(1'b1, 32'h44);
    @(negedge clk);
    check("t6 pre instr_gnt2", {31'd0, b_instr_gnt}, 32'd1);
    step();
    rst_n = 1'b0;
    set_idle();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6 instr_rvalid", {31'd0, b_instr_rvalid}, 32'd0);
      check("t6 data_rvalid", {31'd0, b_data_rvalid}, 32'd0);
      check("t6 conflict_cnt", b_conflict, 32'd0);
      step();
    end
    drive_instr(1'b1, 32'h60);
    drive_data(1'b1, 32'h70, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    check("t6 post instr_gnt", {31'd0, b_instr_gnt}, 32'd1);
    check("t6 post data_gnt", {31'd0, b_data_gnt}, 32'd0);
    step();
    idle_cycles(4);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the core's instruction fetch port (read-only) and data port (read/write).
- Sits in the core testbench between the core's instr/data OBI-style interfaces and the RAM, replacing the dual-port access path.
- Grants at most one request per cycle and returns each response to the port that issued it, in order.
- Counts arbitration conflicts for performance checks.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and the memory.
- DATA_WIDTH, 32, data width of both ports and the memory.
- MEM_LATENCY, 1, cycles from an accepted mem_req_o to valid mem_rdata_i; legal range 1..4.
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed data-port priority.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- data_req_i  in  1  load/store request.
- data_addr_i  in  ADDR_WIDTH  load/store address.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store accepted this cycle.
- data_rvalid_o  out  1  load/store response valid; also asserted for stores.
- data_rdata_o  out  DATA_WIDTH  load data; 0 for stores.
- mem_req_o  out  1  memory access this cycle.
- mem_we_o  out  1  memory write.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the access.
- conflict_cnt_o  out  32  saturating count of cycles in which both ports requested.

Behaviour:
- Reset: one clock, clk_i; rst_ni is synchronous and active-low.
  - While rst_ni is low, all gnt, rvalid, and mem_req_o outputs are 0.
  - rdata outputs, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o and conflict_cnt_o are 0.
  - Round-robin pointer last_grant resets to DATA, so the instruction port wins the first conflict.
- Grant is combinational within the cycle. At most one of instr_gnt_o and data_gnt_o is high.
  - A gnt implies mem_req_o=1 with the winner's fields.
  - For the instruction port, mem_we_o=0 and mem_be_o is all ones.
  - No request: mem_req_o=0 and mem fields are 0.
- Arbitration when only one port requests: that port is granted.
- Arbitration when both request:
  - PRIORITY_MODE=0: the port not in last_grant wins. last_grant updates on every grant, not only on conflicts.
  - PRIORITY_MODE=1: the data port always wins; the instruction port can starve.
- conflict_cnt_o increments by 1 in each cycle where both req inputs are high. It saturates at 0xFFFF_FFFF.
- Response tracking uses a shift pipeline of depth MEM_LATENCY. Each stage holds {valid, owner, we}. Stage 0 is loaded with {mem_req_o, winner, mem_we_o} each cycle.
- Response routing at the last stage, when valid:
  - Assert the owner's rvalid in that cycle.
  - Owner's rdata = mem_rdata_i for reads, 0 for writes.
  - The non-owner port's rvalid is 0 and its rdata is 0.
  - Response latency from gnt is exactly MEM_LATENCY cycles.
- Back-to-back grants sustain one access per cycle. Responses return in grant order, with no reordering and no loss.
- Requesters must hold req and fields stable until gnt; the block does not latch ungranted requests.
- Reset mid-operation: the pipeline clears and in-flight responses are dropped; no rvalid follows the reset. Requesters are assumed to be reset concurrently.
- There is no backpressure on responses: rvalid is not held, and requesters must accept it.

Decomposition:
- Shared package obi_mem_pkg holds:
  - typedef port_id_e {INSTR=1'b0, DATA=1'b1};
  - typedef rsp_stage_t {valid, owner, we};
  - constant MAX_MEM_LATENCY=4.
- One sub-module, obi_rr_arbiter: 2-way arbiter holding the last_grant register and implementing PRIORITY_MODE. Its outputs are gnt[1:0] and winner.

Test Plan:
- Instr-only stream, MEM_LATENCY=1: instr_req held 4 cycles at addresses 0x80, 0x84, 0x88, 0x8C, memory returning addr+1.
  - instr_gnt_o=1 in every cycle; mem_addr_o follows the addresses.
  - instr_rvalid_o goes high 1 cycle after each gnt, with rdata 0x81, 0x85, 0x89, 0x8D.
  - data_rvalid_o stays 0.
- Round-robin conflict: both req high for 4 cycles right after reset.
  - Grants go instr, data, instr, data.
  - conflict_cnt_o=4; responses alternate ports.
- PRIORITY_MODE=1: both req high for 3 cycles, then data_req drops.
  - data_gnt_o=1 for cycles 0-2 and instr_gnt_o=0; instr is granted in cycle 3.
  - conflict_cnt_o=3.
- Store: data_we=1, be=4'b0011, wdata=0xDEADBEEF, addr=0x1000.
  - mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF.
  - data_rvalid_o high MEM_LATENCY cycles later with data_rdata_o=0.
- MEM_LATENCY=3: interleaved instr/data reads granted back-to-back for 6 cycles.
  - Each response appears exactly 3 cycles after its gnt, on the correct port, with matching data and no crossover.
- Reset mid-operation: rst_ni low for 1 cycle with 2 reads in flight (MEM_LATENCY=3).
  - No rvalid in the following 4 cycles; conflict_cnt_o=0.
  - The next conflict is won by instr.
